// File: rtl/i8080_int_ctrl_pkg.sv
// Shared constants, state encodings and opcode helper for the i8080 vectored
// interrupt controller.
package i8080_int_ctrl_pkg;

    localparam logic [7:0] RST_OPCODE_BASE = 8'hC7;
    localparam logic [7:0] SPURIOUS_OPCODE = 8'hFF;
    localparam int         STATUS_INTA_BIT = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INTA = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Selection frozen at the start of an acknowledge cycle.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } ack_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // RST n opcode: 11nnn111.
    function automatic logic [7:0] rst_opcode(input logic [2:0] n);
        return RST_OPCODE_BASE | {2'b00, n, 3'b000};
    endfunction

endpackage

// File: rtl/i8080_int_ctrl_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority.
module int_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/i8080_int_ctrl_sync.sv
// Two-flop synchronizer for one asynchronous request line.
module i8080_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/i8080_int_ctrl.sv
// Vectored interrupt controller: latches requests, applies mask and nested
// fixed priority, and answers the i8080 INTA cycle with an RST opcode.
module i8080_int_ctrl
    import i8080_int_ctrl_pkg::*;
#(
    parameter int XLEN        = 8,
    parameter int NUM_IRQ     = 8,
    parameter int EDGE_MODE   = 1,
    parameter int VECTOR_BASE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               mask_we,
    input  logic               eoi,
    input  logic               sync,
    input  logic [XLEN-1:0]    status,
    input  logic               dbin,
    output logic               cpu_int,
    output logic [XLEN-1:0]    vector_data,
    output logic               vector_oe,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);
    localparam int IDX_W = idx_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] w_irq_s;
    logic [NUM_IRQ-1:0] w_pend_next;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_commit;
    logic [NUM_IRQ-1:0] w_eoi_clr;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_vld;
    logic [IDX_W-1:0]   w_isv_idx;
    logic               w_isv_vld;
    logic [7:0]         w_opcode;
    logic               w_unused_status;

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_isv;
    logic [1:0]         r_state;
    logic               r_dbin_seen;
    ack_t               r_ack;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        i8080_sync2 u_sync (
            .clk   (clk),
            .rst_n (rst),
            .i_d   (irq[g]),
            .o_q   (w_irq_s[g])
        );
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NUM_IRQ-1:0] r_prev;
            logic [NUM_IRQ-1:0] r_rise;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_prev <= '0;
                    r_rise <= '0;
                end else begin
                    r_prev <= w_irq_s;
                    r_rise <= w_irq_s & ~r_prev;
                end
            end

            // A new rise on the acknowledge-clear edge must not be lost.
            assign w_pend_next = (r_pending & ~w_commit) | r_rise;
        end else begin : g_level
            assign w_pend_next = w_irq_s;
        end
    endgenerate

    int_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_isv_enc (
        .i_req   (r_isv),
        .o_idx   (w_isv_idx),
        .o_valid (w_isv_vld)
    );

    // Only channels strictly above the active in-service level may nest.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_elig[i] = r_pending[i] & ~r_mask[i] &
                        (!w_isv_vld || (IDX_W'(i) < w_isv_idx));
        end
    end

    int_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_sel_enc (
        .i_req   (w_elig),
        .o_idx   (w_sel_idx),
        .o_valid (w_sel_vld)
    );

    always_comb begin
        w_commit  = '0;
        w_eoi_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_commit[i]  = (r_state == ST_DONE) && r_ack.valid && (r_ack.id == 3'(i));
            w_eoi_clr[i] = eoi && w_isv_vld && (w_isv_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_isv     <= '0;
        end else begin
            r_pending <= w_pend_next;
            r_isv     <= (r_isv & ~w_eoi_clr) | w_commit;
            if (mask_we) r_mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_dbin_seen <= 1'b0;
            r_ack       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sync && status[STATUS_INTA_BIT]) begin
                        r_state     <= ST_INTA;
                        r_dbin_seen <= 1'b0;
                        r_ack.valid <= w_sel_vld;
                        r_ack.id    <= 3'(w_sel_idx);
                    end
                end
                ST_INTA: begin
                    if (dbin) r_dbin_seen <= 1'b1;
                    else if (r_dbin_seen) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_opcode = SPURIOUS_OPCODE;
        if (r_ack.valid) w_opcode = rst_opcode(3'(VECTOR_BASE) + r_ack.id);
    end

    assign w_unused_status = ^status;
    assign cpu_int         = w_sel_vld;
    assign vector_oe       = (r_state == ST_INTA) && dbin;
    assign vector_data     = (r_state == ST_INTA) ? XLEN'(w_opcode) : '0;
    assign pending         = r_pending;
    assign in_service      = r_isv;

endmodule

// File: tb/tb_i8080_int_ctrl.sv
// Bench for i8080_int_ctrl: vector table, directed corner sequences and a
// randomized run against a request/priority reference model.
module tb_i8080_int_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irq = '0, mask_wdata = '0, status = '0;
    logic       mask_we = 1'b0, eoi = 1'b0, sync = 1'b0, dbin = 1'b0;
    logic       cpu_int, vector_oe;
    logic [7:0] vector_data, pending, in_service;

    logic [7:0] irq_l = '0, status_l = '0, mask_wdata_l = '0;
    logic       mask_we_l = 1'b0, eoi_l = 1'b0, sync_l = 1'b0, dbin_l = 1'b0;
    logic       cpu_int_l, vector_oe_l;
    logic [7:0] vector_data_l, pending_l, in_service_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i8080_int_ctrl #(.XLEN(8), .NUM_IRQ(8), .EDGE_MODE(1), .VECTOR_BASE(0)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_wdata(mask_wdata), .mask_we(mask_we),
        .eoi(eoi), .sync(sync), .status(status), .dbin(dbin), .cpu_int(cpu_int),
        .vector_data(vector_data), .vector_oe(vector_oe), .pending(pending),
        .in_service(in_service)
    );

    i8080_int_ctrl #(.XLEN(8), .NUM_IRQ(8), .EDGE_MODE(0), .VECTOR_BASE(0)) dut_lvl (
        .clk(clk), .rst(rst), .irq(irq_l), .mask_wdata(mask_wdata_l), .mask_we(mask_we_l),
        .eoi(eoi_l), .sync(sync_l), .status(status_l), .dbin(dbin_l), .cpu_int(cpu_int_l),
        .vector_data(vector_data_l), .vector_oe(vector_oe_l), .pending(pending_l),
        .in_service(in_service_l)
    );

    // Reference model of the edge-mode instance
    int         cyc = 0;
    logic [7:0] m_pend = '0, m_mask = '0, m_isv = '0;
    logic [7:0] hq [0:4];
    int         m_commit_cyc = -1;
    logic       m_commit_vld = 1'b0;
    int         m_commit_id = 0;
    logic [7:0] m_set, m_cs, m_ec;

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            m_pend = '0; m_mask = '0; m_isv = '0; m_commit_cyc = -1;
            for (int i = 0; i < 5; i++) hq[i] = '0;
        end else begin
            for (int i = 4; i > 0; i--) hq[i] = hq[i-1];
            hq[0] = irq;
            m_set = hq[3] & ~hq[4];
            m_cs  = (cyc == m_commit_cyc && m_commit_vld) ? (8'd1 << m_commit_id) : 8'd0;
            m_ec  = eoi ? (m_isv & (~m_isv + 8'd1)) : 8'd0;
            m_pend = (m_pend & ~m_cs) | m_set;
            m_isv  = (m_isv & ~m_ec) | m_cs;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    function automatic logic [7:0] m_elig();
        logic [7:0] e;
        int top;
        e = '0;
        top = 8;
        for (int i = 7; i >= 0; i--) if (m_isv[i]) top = i;
        for (int i = 0; i < 8; i++) if (m_pend[i] && !m_mask[i] && i < top) e[i] = 1'b1;
        return e;
    endfunction

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [7:0] m_vec();
        logic [7:0] e;
        e = m_elig();
        if (e == 0) return 8'hFF;
        return 8'hC7 + 8'(lowest(e) * 8);
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cpu_int", 8'(cpu_int), 8'h00);
        chk("rst_vector_oe", 8'(vector_oe), 8'h00);
        chk("rst_vector_data", vector_data, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_in_service", in_service, 8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq = bits;
        @(negedge clk);
        irq = '0;
    endtask

    task automatic mask_write(input logic [7:0] m);
        mask_we = 1'b1;
        mask_wdata = m;
        @(negedge clk);
        mask_we = 1'b0;
    endtask

    task automatic eoi_pulse();
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    // Full INTA machine cycle; commit lands on the fourth edge after sync.
    task automatic do_ack(input string nm, input logic [7:0] exp_vec,
                          input logic [7:0] irq_during, input logic eoi_at_done);
        logic [7:0] e;
        e = m_elig();
        m_commit_vld = (e != 0);
        m_commit_id  = lowest(e);
        m_commit_cyc = cyc + 4;
        sync = 1'b1; status = 8'h23; irq = irq_during;
        @(negedge clk);
        sync = 1'b0; status = 8'h00; irq = '0; dbin = 1'b1;
        #1;
        chk({nm, "_oe"}, 8'(vector_oe), 8'h01);
        chk({nm, "_vec"}, vector_data, exp_vec);
        @(negedge clk);
        dbin = 1'b0;
        #1;
        chk({nm, "_oe_off"}, 8'(vector_oe), 8'h00);
        @(negedge clk);
        if (eoi_at_done) eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [7:0] irq;
        logic [7:0] mask;
        logic       exp_int;
        logic [7:0] exp_vec;
        logic [7:0] exp_isv;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h01, 8'h00, 1'b1, 8'hC7, 8'h01, 8'h00};
        tbl[1] = '{8'h80, 8'h00, 1'b1, 8'hFF, 8'h80, 8'h00};
        tbl[2] = '{8'h28, 8'h00, 1'b1, 8'hDF, 8'h08, 8'h20};
        tbl[3] = '{8'h10, 8'h10, 1'b0, 8'hFF, 8'h00, 8'h10};
        tbl[4] = '{8'h0C, 8'h04, 1'b1, 8'hDF, 8'h08, 8'h04};
        tbl[5] = '{8'h41, 8'h01, 1'b1, 8'hF7, 8'h40, 8'h01};
        tbl[6] = '{8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 7; t++) begin
            do_reset();
            if (tbl[t].mask != 0) mask_write(tbl[t].mask);
            pulse(tbl[t].irq);
            wait_cyc(3);
            chk("tbl_cpu_int", 8'(cpu_int), 8'(tbl[t].exp_int));
            do_ack("tbl_ack", tbl[t].exp_vec, 8'h00, 1'b0);
            chk("tbl_in_service", in_service, tbl[t].exp_isv);
            chk("tbl_pending", pending, tbl[t].exp_pend);
        end

        // Latency and basic acknowledge
        do_reset();
        pulse(8'h02);
        wait_cyc(2);
        chk("t1_pend_early", pending, 8'h00);
        wait_cyc(1);
        chk("t1_pend", pending, 8'h02);
        chk("t1_int", 8'(cpu_int), 8'h01);
        do_ack("t1_ack", 8'hCF, 8'h00, 1'b0);
        chk("t1_pend_after", pending, 8'h00);
        chk("t1_isv", in_service, 8'h02);
        chk("t1_int_after", 8'(cpu_int), 8'h00);

        // Simultaneous requests, lower priority blocked until eoi
        do_reset();
        pulse(8'h24);
        wait_cyc(3);
        do_ack("t2_ack1", 8'hD7, 8'h00, 1'b0);
        chk("t2_isv1", in_service, 8'h04);
        chk("t2_blocked", 8'(cpu_int), 8'h00);
        eoi_pulse();
        #1;
        chk("t2_isv_eoi", in_service, 8'h00);
        chk("t2_int_eoi", 8'(cpu_int), 8'h01);
        do_ack("t2_ack2", 8'hEF, 8'h00, 1'b0);
        chk("t2_isv2", in_service, 8'h20);

        // Nesting
        do_reset();
        pulse(8'h04);
        wait_cyc(3);
        do_ack("t3_pre", 8'hD7, 8'h00, 1'b0);
        pulse(8'h01);
        wait_cyc(3);
        chk("t3_nest_int", 8'(cpu_int), 8'h01);
        do_ack("t3_ack", 8'hC7, 8'h00, 1'b0);
        chk("t3_isv", in_service, 8'h05);
        eoi_pulse();
        #1;
        chk("t3_isv_eoi", in_service, 8'h04);

        // Masking
        do_reset();
        mask_write(8'h02);
        pulse(8'h02);
        wait_cyc(3);
        chk("t4_pend", pending, 8'h02);
        chk("t4_masked", 8'(cpu_int), 8'h00);
        mask_write(8'h00);
        #1;
        chk("t4_unmasked", 8'(cpu_int), 8'h01);

        // Spurious acknowledge
        do_reset();
        mask_write(8'h08);
        pulse(8'h08);
        wait_cyc(3);
        do_ack("t5_ack", 8'hFF, 8'h00, 1'b0);
        chk("t5_pend", pending, 8'h08);
        chk("t5_isv", in_service, 8'h00);

        // Reset in the middle of INTA
        do_reset();
        pulse(8'h02);
        wait_cyc(3);
        sync = 1'b1; status = 8'h01;
        @(negedge clk);
        sync = 1'b0; status = 8'h00; dbin = 1'b1;
        #1;
        chk("t6_oe_before", 8'(vector_oe), 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_oe_reset", 8'(vector_oe), 8'h00);
        chk("t6_data_reset", vector_data, 8'h00);
        chk("t6_pend_reset", pending, 8'h00);
        chk("t6_int_reset", 8'(cpu_int), 8'h00);
        dbin = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        chk("t6_isv_after", in_service, 8'h00);

        // New rise on the acknowledge-clear edge keeps pending
        do_reset();
        pulse(8'h02);
        wait_cyc(3);
        do_ack("t7_ack", 8'hCF, 8'h02, 1'b0);
        chk("t7_pend_setwins", pending, 8'h02);
        chk("t7_isv", in_service, 8'h02);

        // eoi on the commit edge: old level cleared, new level set
        pulse(8'h01);
        wait_cyc(3);
        do_ack("t8_ack", 8'hC7, 8'h00, 1'b1);
        chk("t8_isv", in_service, 8'h01);
        chk("t8_pend", pending, 8'h02);

        // Level-mode instance
        do_reset();
        irq_l = 8'h08;
        wait_cyc(3);
        chk("lvl_pend", pending_l, 8'h08);
        chk("lvl_int", 8'(cpu_int_l), 8'h01);
        sync_l = 1'b1; status_l = 8'h01;
        @(negedge clk);
        sync_l = 1'b0; status_l = 8'h00; dbin_l = 1'b1;
        #1;
        chk("lvl_vec", vector_data_l, 8'hDF);
        @(negedge clk);
        dbin_l = 1'b0;
        wait_cyc(2);
        chk("lvl_pend_kept", pending_l, 8'h08);
        chk("lvl_isv", in_service_l, 8'h08);
        eoi_l = 1'b1;
        @(negedge clk);
        eoi_l = 1'b0;
        #1;
        chk("lvl_int_held", 8'(cpu_int_l), 8'h01);
        irq_l = 8'h00;
        wait_cyc(2);
        chk("lvl_int_still", 8'(cpu_int_l), 8'h01);
        wait_cyc(1);
        chk("lvl_int_fall", 8'(cpu_int_l), 8'h00);
        chk("lvl_pend_fall", pending_l, 8'h00);

        // Randomized run against the model
        do_reset();
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) mask_write(8'($urandom) & 8'($urandom));
            pulse(8'($urandom) & 8'($urandom));
            wait_cyc(3 + $urandom_range(0, 2));
            chk("rnd_pend", pending, m_pend);
            chk("rnd_int", 8'(cpu_int), 8'(m_elig() != 0));
            if ($urandom_range(0, 1) == 1) begin
                do_ack("rnd_ack", m_vec(), 8'h00, $urandom_range(0, 3) == 0);
                chk("rnd_isv", in_service, m_isv);
                chk("rnd_pend_ack", pending, m_pend);
            end
            if ($urandom_range(0, 2) == 0) begin
                eoi_pulse();
                #1;
                chk("rnd_isv_eoi", in_service, m_isv);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
